// File: rtl/neuron_delay_buffer.sv
// Signed delay line with runtime tap select (1..DEPTH cycles), stall, flush and occupancy count.
// Optional build macro NEURON_DELAY_BUFFER_ZERO_INVALID_EN forces out_data to 0 while out_valid is 0.
module neuron_delay_buffer #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8,
    parameter int SELW  = $clog2(DEPTH),
    parameter int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic [SELW-1:0]         dly_sel,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic [OCCW-1:0]         occupancy
);

    logic signed [WIDTH-1:0] data_q [DEPTH];
    logic signed [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0]        vld_d;
    logic [OCCW-1:0]         occ_q;
    logic [OCCW-1:0]         occ_d;
    logic [SELW-1:0]         tap;

    // Selects beyond the last stage (non power-of-2 DEPTH) land on the deepest stage.
    function automatic logic [SELW-1:0] clamp_tap(input logic [SELW-1:0] sel);
        if (int'(sel) > DEPTH - 1) begin
            return SELW'(DEPTH - 1);
        end
        return sel;
    endfunction

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        occ_d  = occ_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            vld_d = '0;
            occ_d = '0;
        end else if (en) begin
            data_d[0] = in_data;
            vld_d[0]  = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            occ_d = occ_q + OCCW'(in_valid) - OCCW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            occ_q  <= occ_d;
        end
    end

    // Output tap is purely combinational so a dly_sel change retaps in the same cycle.
    always_comb begin
        tap       = clamp_tap(dly_sel);
        out_valid = vld_q[tap];
`ifdef NEURON_DELAY_BUFFER_ZERO_INVALID_EN
        out_data  = vld_q[tap] ? data_q[tap] : '0;
`else
        out_data  = data_q[tap];
`endif
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_neuron_delay_buffer.sv
// Scoreboard bench for neuron_delay_buffer: a history-queue reference model feeds expectations to a monitor.
module tb_neuron_delay_buffer;

    localparam int WIDTH = 21;
    localparam int DEPTH = 8;
    localparam int SELW  = $clog2(DEPTH);
    localparam int OCCW  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic                    flush = 1'b0;
    logic signed [WIDTH-1:0] in_data = '0;
    logic                    in_valid = 1'b0;
    logic [SELW-1:0]         dly_sel = '0;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic [OCCW-1:0]         occupancy;

    neuron_delay_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .dly_sel(dly_sel),
        .out_data(out_data), .out_valid(out_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                    vld;
        logic signed [WIDTH-1:0] data;
    } smp_t;

    typedef struct {
        logic                    vld;
        logic signed [WIDTH-1:0] data;
        int                      occ;
    } exp_t;

    // hist[0] is the newest accepted sample; hist[j] is the sample accepted j enabled edges ago.
    smp_t hist[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('{1'b0, '0});
    endfunction

    function automatic void model_edge();
        if (!rst_n || flush) begin
            model_clear();
        end else if (en) begin
            hist.push_front('{in_valid, in_data});
            hist.delete(DEPTH);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   k;
        int   n;
        k = (int'(dly_sel) > DEPTH - 1) ? DEPTH - 1 : int'(dly_sel);
        n = 0;
        foreach (hist[i]) if (hist[i].vld) n++;
        e.vld  = hist[k].vld;
        e.data = hist[k].data;
        e.occ  = n;
        return e;
    endfunction

    task automatic step(input logic e, input logic f, input logic iv, input int d, input int sel);
        @(posedge clk);
        model_edge();
        #1;
        en       = e;
        flush    = f;
        in_valid = iv;
        in_data  = WIDTH'(d);
        dly_sel  = SELW'(sel);
        sb.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        en       = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = WIDTH'(10);
        #1;
        model_clear();
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        check("rst_async_occ", occupancy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_data", out_data, 0);
        check("rst_hold_occ", occupancy, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_valid", out_valid, e.vld);
                check("occupancy", occupancy, e.occ);
`ifdef NEURON_DELAY_BUFFER_ZERO_INVALID_EN
                check("out_data", out_data, e.data);
`else
                if (e.vld) check("out_data", out_data, e.data);
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_clear();
        do_reset();

        // Fixed delay of one cycle, occupancy climbing then saturating at DEPTH.
        for (int i = 0; i < 11; i++) step(1, 0, 1, i * 8, 0);

        // Flush, then a single min-signed sample through the deepest tap.
        step(1, 1, 0, 0, 7);
        step(1, 0, 1, -1048576, 7);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 7);

        // Stall for five cycles after sample 2.
        step(1, 1, 0, 0, 3);
        step(1, 0, 1, 1, 3);
        step(1, 0, 1, 2, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 77, 3);
        step(1, 0, 1, 3, 3);
        step(1, 0, 1, 4, 3);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 3);

        // Flush priority over en with a valid input present.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 50 + i, 4);
        step(1, 1, 1, 99, 4);
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 0, i % DEPTH);

        // Retap from delay 3 to delay 1 mid-stream.
        for (int i = 1; i <= 6; i++) step(1, 0, 1, i * 10, 2);
        for (int i = 7; i <= 10; i++) step(1, 0, 1, i * 10, 0);
        step(1, 0, 0, 0, 1);

        // Reset asserted mid-stream.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 1, -5 - i, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 5) != 0, ($urandom % 25) == 0, ($urandom % 3) != 0,
                 int'($urandom), int'($urandom_range(0, DEPTH - 1)));
        end
        step(1, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_delay_buffer.md
Name: neuron_delay_buffer

Overview:
- Parametrised signed delay line for neuron datapath samples; successor to the single-register buffer.
- Delays a signed sample stream by a runtime-selectable 1..DEPTH clock cycles, carrying a valid bit with each sample.
- Adds stall (en), synchronous flush, and a pipeline occupancy count.
- Sits between the synapse accumulator and the neuron membrane update, where it aligns axonal/synaptic delays.

Parameters:
- WIDTH, 21, signed sample width in bits.
- DEPTH, 8, number of register stages (>=2); maximum delay in cycles.
- SELW, $clog2(DEPTH), width of dly_sel.
- OCCW, $clog2(DEPTH+1), width of occupancy.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; 0 = stall/hold all state.
- flush  input  1  synchronous clear of all valid bits and occupancy.
- in_data  input  WIDTH signed  incoming sample.
- in_valid  input  1  in_data qualifier.
- dly_sel  input  SELW  tap select; delay = dly_sel+1 cycles.
- out_data  output  WIDTH signed  delayed sample.
- out_valid  output  1  out_data qualifier.
- occupancy  output  OCCW  number of valid samples held in stages 0..DEPTH-1.

Behaviour:
- Reset is asynchronous, active-low. All stage data = 0, all stage valid = 0, occupancy = 0, so out_data = 0 and out_valid = 0 immediately on assertion.
- Storage is stage[0..DEPTH-1], each holding {valid, data}.
- On a clk edge with en=1 and flush=0:
  - stage[0] <= {in_valid, in_data};
  - stage[i] <= stage[i-1] for i >= 1;
  - stage[DEPTH-1] contents are discarded.
- Data is shifted whether or not valid; invalid samples still occupy slots.
- out_data/out_valid = stage[k] through a combinational mux, k = min(dly_sel, DEPTH-1).
  - A sample presented at edge N appears at the output after edge N+dly_sel (delay dly_sel+1 cycles, counted with en=1).
  - dly_sel >= DEPTH (possible when DEPTH is not a power of 2) clamps to DEPTH-1.
- dly_sel change mid-stream: the output retaps on the same cycle, with no flush and no re-timing.
  - Samples may be repeated (delay increased) or skipped (delay decreased); this is intended.
- en=0: all stages and occupancy hold; outputs hold (dly_sel still muxes live).
- Occupancy:
  - With en=1, flush=0: occupancy <= occupancy + in_valid - stage[DEPTH-1].valid.
  - It never exceeds DEPTH and never underflows.
- flush=1 (sampled at clk edge):
  - all valid bits <= 0 and occupancy <= 0;
  - data registers <= 0;
  - in_valid on that edge is dropped.
  - flush has priority over en.
  - out_valid = 0 the cycle after flush.
- No arithmetic is performed on the data: it is passed through bit-exact, signed, with no width change.
- Reset asserted mid-stream: all state clears immediately; the first valid output after deassertion requires a fresh sample.

Optional Feature:
- Macro: NEURON_DELAY_BUFFER_ZERO_INVALID_EN.
- Defined: out_data is forced to 0 whenever out_valid = 0, so downstream accumulators may sum without gating.
- Undefined: out_data shows the raw stage data regardless of valid (smaller; data from invalid slots is don't-care).
- Occupancy, valid and timing are identical in both builds.

Test Plan:
- Reset: rst_n=0 with in_data=10, in_valid=1, en=1 -> out_data=0, out_valid=0, occupancy=0 throughout; async clear is observed mid-cycle, without waiting for a clk edge.
- Fixed delay: dly_sel=0, en=1, in_valid=1, in_data=i*8 for i=0..5 on consecutive edges -> out_data=0,8,16,...,40 one cycle after each input; occupancy rises to 6 and saturates at 8 if inputs continue.
- Max delay: dly_sel=7 (DEPTH=8), single valid sample -1048576 (min signed 21-bit) -> appears bit-exact exactly 8 edges later with out_valid=1 for one cycle.
- Stall: dly_sel=3, stream 1,2,3,4, deassert en for 5 cycles after sample 2 -> output and occupancy frozen during the stall; sample 1 emerges 4 enabled edges after entry.
- Flush priority: pipeline holding 5 valid samples, assert flush=1 with en=1 and in_valid=1, in_data=99 -> next cycle occupancy=0, out_valid=0; 99 never appears at the output.
- Retap and optional feature: stream 10,20,30,... with dly_sel=2, switch to 0 mid-stream -> output jumps to the newest sample next cycle. With NEURON_DELAY_BUFFER_ZERO_INVALID_EN defined, out_data=0 whenever out_valid=0; undefined, no check on out_data while out_valid=0.
